// File: rtl/interface_circuit_pkg.sv
// Shared definitions for the rx -> alu -> tx glue: default widths, FSM state
// encodings and the ALU opcode constants used by the alu and the benches.
package interface_circuit_pkg;

  localparam int DEF_WIDTH_WORD       = 8;
  localparam int DEF_CANT_BITS_OPCODE = 6;

  typedef enum logic [2:0] {
    ST_A       = 3'd0,
    ST_B       = 3'd1,
    ST_OP      = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  // States in which an incoming byte cannot be accepted.
  function automatic logic is_busy(input state_e s);
    return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/interface_circuit_edge_detector.sv
// Rising-edge detector: registers the level input and pulses for one cycle
// when it goes from 0 to 1, so a held level yields a single event.
module interface_circuit_edge_detector (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/interface_circuit.sv
// Collects operand A, operand B and opcode from the rx stage, presents them to
// the ALU, latches the result and hands it to the tx stage.
module interface_circuit
  import interface_circuit_pkg::*;
#(
  parameter int WIDTH_WORD       = DEF_WIDTH_WORD,
  parameter int CANT_BITS_OPCODE = DEF_CANT_BITS_OPCODE
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_rx_done,
  input  logic [WIDTH_WORD-1:0]       i_data_rx,
  input  logic [WIDTH_WORD-1:0]       i_alu_result,
  input  logic                        i_tx_done,
  output logic [WIDTH_WORD-1:0]       o_reg_A,
  output logic [WIDTH_WORD-1:0]       o_reg_B,
  output logic [CANT_BITS_OPCODE-1:0] o_reg_opcode,
  output logic                        o_tx_start,
  output logic [WIDTH_WORD-1:0]       o_data_tx,
  output logic                        o_overrun,
  output logic [2:0]                  o_state
);

  // Tx handshake: o_tx_start is a single-cycle pulse in ST_SEND; o_data_tx is
  // held from that pulse until i_tx_done is seen in ST_WAIT_TX. i_tx_done in
  // any other state, including the start cycle itself, is ignored.

  state_e                      state_q, state_d;
  logic [WIDTH_WORD-1:0]       reg_a_q, reg_a_d;
  logic [WIDTH_WORD-1:0]       reg_b_q, reg_b_d;
  logic [CANT_BITS_OPCODE-1:0] reg_op_q, reg_op_d;
  logic [WIDTH_WORD-1:0]       data_tx_q, data_tx_d;
  logic                        overrun_q, overrun_d;
  logic                        rx_event;

  interface_circuit_edge_detector u_rx_edge (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .level_i (i_rx_done),
    .pulse_o (rx_event)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_A;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      reg_op_q  <= '0;
      data_tx_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      reg_op_q  <= reg_op_d;
      data_tx_q <= data_tx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    reg_op_d   = reg_op_q;
    data_tx_d  = data_tx_q;
    overrun_d  = overrun_q;
    o_tx_start = 1'b0;

    case (state_q)
      ST_A: begin
        if (rx_event) begin
          reg_a_d = i_data_rx;
          state_d = ST_B;
        end
      end
      ST_B: begin
        if (rx_event) begin
          reg_b_d = i_data_rx;
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        if (rx_event) begin
          reg_op_d = i_data_rx[CANT_BITS_OPCODE-1:0];
          state_d  = ST_EXEC;
        end
      end
      // Operands were registered on the previous edge, so the ALU output is settled.
      ST_EXEC: begin
        data_tx_d = i_alu_result;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        o_tx_start = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_A;
        end
      end
      default: begin
        state_d = ST_A;
      end
    endcase

    if (rx_event && is_busy(state_q)) begin
      overrun_d = 1'b1;
    end
  end

  assign o_reg_A      = reg_a_q;
  assign o_reg_B      = reg_b_q;
  assign o_reg_opcode = reg_op_q;
  assign o_data_tx    = data_tx_q;
  assign o_overrun    = overrun_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_interface_circuit.sv
// Directed bench for interface_circuit: byte drivers, a small ALU model, a tx
// scoreboard fed with hand-computed results, and a one-line final report.
module tb_interface_circuit;
  import interface_circuit_pkg::*;

  logic       clk;
  logic       i_reset;
  logic       i_rx_done;
  logic [7:0] i_data_rx;
  logic [7:0] i_alu_result;
  logic       i_tx_done;
  logic [7:0] o_reg_A;
  logic [7:0] o_reg_B;
  logic [5:0] o_reg_opcode;
  logic       o_tx_start;
  logic [7:0] o_data_tx;
  logic       o_overrun;
  logic [2:0] o_state;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [7:0] exp_q[$];

  interface_circuit dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_rx_done    (i_rx_done),
    .i_data_rx    (i_data_rx),
    .i_alu_result (i_alu_result),
    .i_tx_done    (i_tx_done),
    .o_reg_A      (o_reg_A),
    .o_reg_B      (o_reg_B),
    .o_reg_opcode (o_reg_opcode),
    .o_tx_start   (o_tx_start),
    .o_data_tx    (o_data_tx),
    .o_overrun    (o_overrun),
    .o_state      (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model
  always_comb begin
    i_alu_result = 8'h00;
    case (o_reg_opcode)
      OP_ADD: i_alu_result = o_reg_A + o_reg_B;
      OP_SUB: i_alu_result = o_reg_A - o_reg_B;
      OP_AND: i_alu_result = o_reg_A & o_reg_B;
      OP_OR:  i_alu_result = o_reg_A | o_reg_B;
      OP_XOR: i_alu_result = o_reg_A ^ o_reg_B;
      default: i_alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (all start and end at a falling edge)
  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    i_rx_done = 1'b1;
    i_data_rx = d;
    @(negedge clk);
    i_rx_done = 1'b0;
    i_data_rx = 8'($urandom_range(0, 255));
  endtask

  task automatic hold_byte(input logic [7:0] d, input int n);
    @(negedge clk);
    i_rx_done = 1'b1;
    i_data_rx = d;
    repeat (n) @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    int n = 0;
    while (o_state !== st && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(o_state), 32'(st));
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] res);
    exp_q.push_back(res);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    wait_state("txn_wait_tx", 3'(ST_WAIT_TX));
    check("txn_data_tx", 32'(o_data_tx), 32'(res));
    pulse_tx_done();
    check("txn_back_to_a", 32'(o_state), 32'(ST_A));
  endtask

  // scoreboard: every start pulse must carry the next expected byte
  always @(negedge clk) begin
    if (o_tx_start === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else check("tx_data", 32'(o_data_tx), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int pulses_before;
    i_reset   = 1'b1;
    i_rx_done = 1'b0;
    i_data_rx = 8'h00;
    i_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(o_state), 32'(ST_A));
    check("rst_outputs", {o_reg_A, o_reg_B, 2'b00, o_reg_opcode, o_data_tx}, 32'h0);
    check("rst_start_ovr", {30'd0, o_tx_start, o_overrun}, 32'd0);
    i_reset = 1'b0;
    @(negedge clk);

    // 1: basic ADD, exact start-pulse timing, tx_done in start cycle ignored
    exp_q.push_back(8'h08);
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    check("t1_reg_A", 32'(o_reg_A), 32'h05);
    check("t1_reg_B", 32'(o_reg_B), 32'h03);
    check("t1_opcode", 32'(o_reg_opcode), 32'h20);
    check("t1_exec_state", 32'(o_state), 32'(ST_EXEC));
    check("t1_start_c1", 32'(o_tx_start), 32'd0);
    @(negedge clk);
    check("t1_start_c2", 32'(o_tx_start), 32'd1);
    check("t1_data_tx", 32'(o_data_tx), 32'h08);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    check("t1_start_c3", 32'(o_tx_start), 32'd0);
    check("t1_done_in_send_ignored", 32'(o_state), 32'(ST_WAIT_TX));
    repeat (2) @(negedge clk);
    check("t1_data_hold", 32'(o_data_tx), 32'h08);
    pulse_tx_done();
    check("t1_back_to_a", 32'(o_state), 32'(ST_A));

    // tx_done while idle is ignored
    pulse_tx_done();
    check("idle_tx_done_ignored", 32'(o_state), 32'(ST_A));

    // 2: held rx_done is one event
    hold_byte(8'hAA, 10);
    check("t2_reg_A", 32'(o_reg_A), 32'hAA);
    check("t2_state_b", 32'(o_state), 32'(ST_B));
    exp_q.push_back(8'h0A);
    send_byte(8'h0F);
    send_byte(8'h24);
    wait_state("t2_wait_tx", 3'(ST_WAIT_TX));
    pulse_tx_done();

    // 3: opcode truncation 0xE2 -> SUB; 4: overrun while waiting for tx
    exp_q.push_back(8'h02);
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'hE2);
    check("t3_opcode", 32'(o_reg_opcode), 32'h22);
    wait_state("t3_wait_tx", 3'(ST_WAIT_TX));
    check("t3_data_tx", 32'(o_data_tx), 32'h02);
    check("t4_no_ovr_yet", 32'(o_overrun), 32'd0);
    send_byte(8'h77);
    check("t4_overrun", 32'(o_overrun), 32'd1);
    check("t4_reg_A_kept", 32'(o_reg_A), 32'h05);
    check("t4_still_wait", 32'(o_state), 32'(ST_WAIT_TX));
    pulse_tx_done();
    send_byte(8'h44);
    check("t4_next_A", 32'(o_reg_A), 32'h44);
    check("t4_ovr_sticky", 32'(o_overrun), 32'd1);

    // 5: asynchronous reset mid-operation
    send_byte(8'h55);
    check("t5_reg_B", 32'(o_reg_B), 32'h55);
    @(posedge clk);
    #2 i_reset = 1'b1;
    #1;
    check("t5_rst_state", 32'(o_state), 32'(ST_A));
    check("t5_rst_regs", {o_reg_A, o_reg_B, 2'b00, o_reg_opcode, o_data_tx}, 32'h0);
    check("t5_rst_ovr", 32'(o_overrun), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;
    run_txn(8'h10, 8'h20, 8'h25, 8'h30);

    // 6: back-to-back with wrap
    pulses_before = pulses;
    run_txn(8'h09, 8'h04, 8'h22, 8'h05);
    run_txn(8'hFF, 8'h01, 8'h20, 8'h00);
    check("t6_two_pulses", 32'(pulses - pulses_before), 32'd2);
    check("t6_no_overrun", 32'(o_overrun), 32'd0);

    // final report
    check("total_pulses", 32'(pulses), 32'd6);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
